// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and helpers for the multi-channel divider
package clkdiv_pkg;

  localparam int MIN_DIV = 2;

  // Periods below MIN_DIV cannot produce a distinct wrap cycle, so writes are clamped up.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
  endfunction

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: counter, active/shadow config, registered outputs
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  input  logic [WIDTH-1:0] wr_high,
  output logic             clkout,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV / 2);

  logic [WIDTH-1:0] per;
  logic [WIDTH-1:0] high;
  logic [WIDTH-1:0] per_sh;
  logic [WIDTH-1:0] high_sh;
  logic [WIDTH-1:0] cnt;

  logic [WIDTH-1:0] per_new;
  logic [WIDTH-1:0] high_new;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] per_wr;
  logic             at_wrap;

  always_comb begin
    per_new  = pending ? per_sh : per;
    high_new = pending ? high_sh : high;
    cnt_inc  = cnt + WIDTH'(1);
    at_wrap  = (cnt == per - WIDTH'(1));
    per_wr   = WIDTH'(clamp_div(32'(wr_div)));
  end

  // A write landing on a wrap or disabled edge is registered after the shadow is consumed,
  // so that edge still applies the previous shadow and the new one waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      per     <= DEF_P;
      high    <= DEF_H;
      per_sh  <= DEF_P;
      high_sh <= DEF_H;
      cnt     <= DEF_P - WIDTH'(1);
      pending <= 1'b0;
      clkout  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!en) begin
        per     <= per_new;
        high    <= high_new;
        pending <= 1'b0;
        cnt     <= per_new - WIDTH'(1);
        clkout  <= 1'b0;
        tick    <= 1'b0;
      end else if (at_wrap) begin
        per     <= per_new;
        high    <= high_new;
        pending <= 1'b0;
        cnt     <= '0;
        tick    <= 1'b1;
        clkout  <= (high_new != '0);
      end else begin
        cnt     <= cnt_inc;
        tick    <= 1'b0;
        clkout  <= (cnt_inc < high);
      end
      if (wr) begin
        per_sh  <= per_wr;
        high_sh <= wr_high;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable clock/tick generator top
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10_000,
  localparam int CH_W       = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_div,
  input  logic [WIDTH-1:0]    load_high,
  output logic [CHANNELS-1:0] clkout,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] wr;

  // Out-of-range channel indices match no strobe and are silently dropped.
  always_comb begin
    wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = load && (load_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clkdiv_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .wr      (wr[g]),
      .wr_div  (load_div),
      .wr_high (load_high),
      .clkout  (clkout[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - bench for clkdiv_multi with a period-position reference model
module tb_clkdiv_multi;

  localparam int CHANNELS    = 5;
  localparam int WIDTH       = 16;
  localparam int DEFAULT_DIV = 10_000;
  localparam int CH_W        = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [CHANNELS-1:0] en;
  logic                load;
  logic [CH_W-1:0]     load_ch;
  logic [WIDTH-1:0]    load_div;
  logic [WIDTH-1:0]    load_high;
  logic [CHANNELS-1:0] clkout;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;

  always #5 clk = ~clk;

  clkdiv_multi #(
    .CHANNELS    (CHANNELS),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .load_high (load_high),
    .clkout    (clkout),
    .tick      (tick),
    .pending   (pending)
  );

  int asserts = 0;
  int fails   = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel tracks its position within the current period (-1 = waiting to start).
  int m_p[CHANNELS], m_h[CHANNELS], m_ps[CHANNELS], m_hs[CHANNELS], m_pos[CHANNELS];
  bit m_pend[CHANNELS], m_clk[CHANNELS], m_tick[CHANNELS];

  always @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (rst) begin
        m_p[c] = DEFAULT_DIV; m_ps[c] = DEFAULT_DIV;
        m_h[c] = DEFAULT_DIV / 2; m_hs[c] = DEFAULT_DIV / 2;
        m_pos[c] = -1; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        if (en[c]) begin
          if (m_pos[c] < 0 || m_pos[c] == m_p[c] - 1) begin
            if (m_pend[c]) begin m_p[c] = m_ps[c]; m_h[c] = m_hs[c]; m_pend[c] = 0; end
            m_pos[c] = 0;
          end else begin
            m_pos[c] = m_pos[c] + 1;
          end
          m_tick[c] = (m_pos[c] == 0);
          m_clk[c]  = (m_pos[c] < m_h[c]);
        end else begin
          if (m_pend[c]) begin m_p[c] = m_ps[c]; m_h[c] = m_hs[c]; m_pend[c] = 0; end
          m_pos[c] = -1; m_tick[c] = 0; m_clk[c] = 0;
        end
        if (load && int'(load_ch) == c) begin
          m_ps[c] = (int'(load_div) < 2) ? 2 : int'(load_div);
          m_hs[c] = int'(load_high);
          m_pend[c] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int c = 0; c < CHANNELS; c++) begin
        check($sformatf("ch%0d_clkout", c), 32'(clkout[c]), 32'(m_clk[c]));
        check($sformatf("ch%0d_tick", c), 32'(tick[c]), 32'(m_tick[c]));
        check($sformatf("ch%0d_pending", c), 32'(pending[c]), 32'(m_pend[c]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write(input int ch, input int div, input int high);
    load = 1'b1; load_ch = CH_W'(ch); load_div = WIDTH'(div); load_high = WIDTH'(high);
    step(1);
    load = 1'b0;
  endtask

  // Steps until the channel ticks; n is the number of cycles taken (bounded).
  task automatic gap(input int ch, output int n);
    n = 0;
    do begin step(1); n++; end while (!tick[ch] && n < 200);
  endtask

  // Waits for the next tick, then returns its period length and high-cycle count.
  task automatic measure(input int ch, output int per, output int hi);
    int n;
    gap(ch, n);
    per = 0; hi = 0;
    do begin hi += int'(clkout[ch]); step(1); per++; end while (!tick[ch] && per < 200);
  endtask

  int n, per, hi;
  logic [5:0] pat;

  initial begin
    rst = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_div = '0; load_high = '0;
    step(3);
    checking = 1;
    check("reset_clkout", 32'(clkout), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_pending", 32'(pending), 32'h0);
    rst = 1'b0;

    write(1, 4, 2);
    en[0] = 1'b1; en[1] = 1'b1;
    fork
      begin : ch0_defaults
        int t, h;
        t = 0; h = 0;
        for (int i = 0; i < 20000; i++) begin
          step(1);
          if (i == 0) check("ch0_first_tick", 32'(tick[0]), 32'h1);
          t += int'(tick[0]);
          h += int'(clkout[0]);
        end
        check("ch0_tick_count", t, 2);
        check("ch0_high_count", h, 10000);
      end
      begin : ch1_reprogram
        int k;
        step(2);
        write(1, 6, 2);
        check("ch1_pending_set", 32'(pending[1]), 32'h1);
        gap(1, k);
        check("ch1_old_period_done", k, 2);
        check("ch1_pending_clear", 32'(pending[1]), 32'h0);
        pat[5] = clkout[1];
        for (int j = 4; j >= 0; j--) begin step(1); pat[j] = clkout[1]; end
        check("ch1_pattern", 32'(pat), 32'h30);
        step(1);
        check("ch1_next_tick", 32'(tick[1]), 32'h1);
      end
    join

    write(2, 0, 1);
    en[2] = 1'b1;
    measure(2, per, hi);
    check("clamp_p0_period", per, 2);
    write(2, 1, 1);
    measure(2, per, hi);
    check("clamp_p1_period", per, 2);
    write(2, 5, 0);
    measure(2, per, hi);
    check("h0_period", per, 5);
    check("h0_high", hi, 0);
    write(2, 5, 9);
    measure(2, per, hi);
    check("hbig_period", per, 5);
    check("hbig_high", hi, 5);

    step(4);
    write(2, 3, 1);
    check("wrap_write_tick", 32'(tick[2]), 32'h1);
    gap(2, n);
    check("wrap_write_old_period", n, 5);
    check("wrap_write_applied", 32'(pending[2]), 32'h0);
    gap(2, n);
    check("wrap_write_new_period", n, 3);

    write(5, 7, 3);
    write(7, 2, 2);
    check("bad_ch_no_pending", 32'(pending), 32'h0);

    write(3, 7, 3);
    en[3] = 1'b1;
    step(3);
    write(3, 4, 1);
    check("ch3_pending", 32'(pending[3]), 32'h1);
    en[3] = 1'b0;
    step(1);
    check("ch3_dis_clkout", 32'(clkout[3]), 32'h0);
    check("ch3_dis_tick", 32'(tick[3]), 32'h0);
    check("ch3_dis_pending", 32'(pending[3]), 32'h0);
    step(3);
    en[3] = 1'b1;
    step(1);
    check("ch3_reenable_tick", 32'(tick[3]), 32'h1);
    gap(3, n);
    check("ch3_new_period", n, 4);

    en = '1;
    write(4, 9, 4);
    step(7);
    rst = 1'b1;
    step(1);
    check("midrst_clkout", 32'(clkout), 32'h0);
    check("midrst_tick", 32'(tick), 32'h0);
    check("midrst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    step(1);
    check("post_rst_ticks", 32'(tick), 32'h1f);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        int c;
        c = int'($urandom_range(0, CHANNELS - 1));
        en[c] = ~en[c];
      end
      load      = ($urandom_range(0, 2) == 0);
      load_ch   = CH_W'($urandom_range(0, 7));
      load_div  = WIDTH'($urandom_range(0, 12));
      load_high = WIDTH'($urandom_range(0, 14));
      rst       = ($urandom_range(0, 399) == 0);
      step(1);
    end
    load = 1'b0; rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Multi-channel programmable clock/tick generator; successor to the fixed single-channel divider. Each of `CHANNELS` independent channels divides `clk` by a runtime-programmable period with a programmable high time, producing a duty-controlled `clkout` and a one-cycle `tick` at each period start. Reprogramming is glitch-free: new settings take effect only at a period boundary. It sits beside the board clock and feeds display-multiplex, debounce and blink logic.

## Interface
- `CHANNELS`, 4: number of independent channels (≥1)
- `WIDTH`, 16: width of the period and high-time registers
- `DEFAULT_DIV`, 10_000: period loaded at reset (2 ≤ DEFAULT_DIV < 2^WIDTH)
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous and active-high
- `en` in CHANNELS: per-channel run enable
- `load` in 1: config write strobe, one write per cycle
- `load_ch` in CH_W = max(1,$clog2(CHANNELS)): target channel
- `load_div` in WIDTH: new period P, in clk cycles
- `load_high` in WIDTH: new high time H, in clk cycles
- `clkout` out CHANNELS: divided clock, registered
- `tick` out CHANNELS: one-cycle pulse at period start, registered
- `pending` out CHANNELS: shadow config not yet applied

## Operation
- Per channel: active (P, H), shadow (Ps, Hs), pending flag, counter `cnt` (WIDTH bits).
- Reset: P = Ps = DEFAULT_DIV, H = Hs = DEFAULT_DIV/2, cnt = DEFAULT_DIV−1, pending = 0, clkout = 0, tick = 0. Defaults reproduce the old 50 % divider.
- Write (`load`=1, `load_ch` < CHANNELS): Ps ← max(load_div, 2); Hs ← load_high; pending ← 1. `load_ch` ≥ CHANNELS: ignored, no state change.
- Enabled, cnt ≠ P−1: cnt ← cnt+1; clkout ← (cnt+1 < H); tick ← 0.
- Enabled, cnt = P−1 (wrap): cnt ← 0; tick ← 1; if pending then P ← Ps, H ← Hs, pending ← 0; clkout ← (0 < H_new), with H_new the value in force after the wrap.
- Disabled: cnt ← P_new−1 (wrap-ready); clkout ← 0; tick ← 0; a pending shadow is applied immediately (P_new = Ps, pending ← 0).
- Duty: H = 0 gives clkout constant 0; H ≥ P gives constant 1. tick still pulses each period.
- Arithmetic unsigned, WIDTH bits; compares never overflow since cnt ≤ P−1 < 2^WIDTH.

## Timing
- First enabled edge after en rises: wrap, so tick = 1 and clkout = (H≠0) in that same cycle. Every period is exactly P cycles, with clkout high exactly min(H,P) cycles starting at the tick cycle.
- Write in cycle k: pending = 1 from k+1. Applied at the first wrap or disabled edge strictly after k.
- Write coinciding with a wrap of the same channel: that wrap uses the prior shadow state. The new values apply at the following wrap.
- Two writes to the same channel before a wrap: last write wins.
- `rst` overrides `en` and `load` in the same cycle. Reset mid-period returns outputs to 0 at the next edge.
- en falling: clkout and tick are 0 from the next cycle.

## Structure
- Package `clkdiv_pkg`: `MIN_DIV` = 2 and the write-clamp function.
- Sub-module `clkdiv_chan` holds one channel (counter, active/shadow, pending, outputs). The top module instantiates it CHANNELS times via generate, and decodes `load`/`load_ch` into per-channel write strobes.

## Test plan
- Reset, en = 1 on ch0 with defaults: tick on the first enabled cycle and every 10 000 cycles after; clkout high 5 000 cycles, low 5 000.
- Write ch1 P = 6, H = 2 mid-period while it runs P = 4, H = 2: the current 4-cycle period completes, then clkout pattern 110000 repeats; pending goes 1 → 0 at the wrap.
- Write P = 0, then P = 1: both clamp to period 2. Write H = 0 gives clkout stuck at 0; write H = 9 with P = 5 gives clkout stuck at 1; tick every 5 cycles in all cases.
- Write exactly on a wrap cycle of ch2: the old period repeats once, then the new period applies. Write with load_ch = CHANNELS (non-power-of-two count): no channel changes.
- Disable ch3 mid-period with a pending write, then re-enable: clkout/tick 0 while disabled, pending clears while disabled, and on re-enable tick fires the first cycle with the new period.
- Assert rst mid-period on all channels with mixed configs: next cycle all outputs 0 and defaults are restored; the channels run independently and simultaneously afterwards.
